round_robin_mux_arbiter: RTL and testbench

Shares one W-bit output channel between NUM_WAY requesters. Each cycle it selects one valid requester with a rotating-priority arbiter, steers that requester's word through a `mux_decoded` instance using the one-hot grant as `sel_in`, and captures the word in a single-entry output register with a valid/ready handshake. It sits in front of any shared downstream resource (port, queue, bus) that accepts one request per cycle.

---
 rtl/round_robin_mux_arbiter.sv | 84 ++++++++
 tb/tb_round_robin_mux_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/round_robin_mux_arbiter.sv
// round_robin_mux_arbiter: round-robin arbiter muxing NUM_WAY request words into one registered valid/ready output; ROUND_ROBIN_MUX_ARBITER_ROTATE_EN selects rotating (defined) vs fixed way-0-first priority
module round_robin_mux_arbiter #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY = 8
) (
  input  logic                                        clk_in,
  input  logic                                        reset_in,
  input  logic [NUM_WAY-1:0]                          request_valid_flatted_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] request_flatted_in,
  output logic [NUM_WAY-1:0]                          issue_ack_out,
  output logic                                        request_valid_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         request_out,
  output logic [NUM_WAY-1:0]                          request_way_out,
  input  logic                                        request_ready_in
);
  localparam int W = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int N = NUM_WAY;
  logic         load;
  logic [N-1:0] req, grant;
  logic [W-1:0] mux_word;
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [N-1:0] way_q, way_d;
  assign load = !valid_q || request_ready_in;
  assign req = request_valid_flatted_in & {N{load && !reset_in}};
`ifdef ROUND_ROBIN_MUX_ARBITER_ROTATE_EN
  logic [N-1:0]   ptr_q, ptr_d;
  logic [2*N-1:0] dbl_req, dbl_gnt;
  // Subtracting the one-hot pointer from the doubled request vector borrows
  // through to the first request at or above the pointer, wrapping into the upper copy.
  assign dbl_req = {req, req};
  assign dbl_gnt = dbl_req & ~(dbl_req - {{N{1'b0}}, ptr_q});
  assign grant = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
  always_comb begin
    ptr_d = |grant ? {grant[N-2:0], grant[N-1]} : ptr_q;
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) ptr_q <= {{(N-1){1'b0}}, 1'b1};
    else ptr_q <= ptr_d;
  end
`else
  assign grant = req & (~req + N'(1));
`endif
  mux_decoded #(.SINGLE_WAY_WIDTH_IN_BITS(W), .NUM_WAY(N)) u_mux (
    .sel_in          (grant),
    .data_flatted_in (request_flatted_in),
    .data_out        (mux_word)
  );
  always_comb begin
    valid_d = load ? |grant : valid_q;
    data_d  = |grant ? mux_word : data_q;
    way_d   = |grant ? grant : way_q;
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      way_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      way_q   <= way_d;
    end
  end
  assign issue_ack_out     = grant;
  assign request_valid_out = valid_q;
  assign request_out       = data_q;
  assign request_way_out   = way_q;
endmodule

module mux_decoded #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY = 8
) (
  input  logic [NUM_WAY-1:0]                          sel_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] data_flatted_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         data_out
);
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_WAY; i++)
      data_out |= {SINGLE_WAY_WIDTH_IN_BITS{sel_in[i]}} & data_flatted_in[i*SINGLE_WAY_WIDTH_IN_BITS +: SINGLE_WAY_WIDTH_IN_BITS];
  end
endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// tb_round_robin_mux_arbiter: scoreboard bench for round_robin_mux_arbiter in either ROUND_ROBIN_MUX_ARBITER_ROTATE_EN build
module tb_round_robin_mux_arbiter;
  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic [7:0]  valid_in = '0;
  logic [31:0] data_in = {4'ha, 4'hb, 4'hc, 4'hd, 4'h1, 4'h2, 4'h3, 4'h4};
  logic        ready_in = 1'b1;
  logic [7:0]  ack, wout;
  logic        vout;
  logic [3:0]  dout;
  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] q[$];
  logic [3:0]  words [8] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hd, 4'hc, 4'hb, 4'ha};
  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_data = '0;
  logic [7:0]  m_way = '0;
  logic [7:0]  last_ack;
  always #5 clk = ~clk;
  round_robin_mux_arbiter #(.SINGLE_WAY_WIDTH_IN_BITS(4), .NUM_WAY(8)) dut (
    .clk_in                   (clk),
    .reset_in                 (reset_in),
    .request_valid_flatted_in (valid_in),
    .request_flatted_in       (data_in),
    .issue_ack_out            (ack),
    .request_valid_out        (vout),
    .request_out              (dout),
    .request_way_out          (wout),
    .request_ready_in         (ready_in)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic [7:0] v, input logic rdy, input logic rst);
    logic [7:0]  exp_ack;
    logic [11:0] e;
    int          g;
    valid_in = v;
    ready_in = rdy;
    reset_in = rst;
    exp_ack = '0;
    g = -1;
    if (!rst && (!m_valid || rdy))
      for (int k = 0; k < 8; k++)
        if (g < 0 && v[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
    if (g >= 0) begin
      exp_ack[g] = 1'b1;
      q.push_back({words[g], exp_ack});
    end
    #1;
    check("ack", ack, exp_ack);
    last_ack = ack;
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_data = '0;
      m_way = '0;
      m_ptr = 0;
      q.delete();
    end else if (!m_valid || rdy) begin
      m_valid = (g >= 0);
      if (g >= 0 && q.size() > 0) begin
        e = q.pop_front();
        m_data = e[11:8];
        m_way = e[7:0];
`ifdef ROUND_ROBIN_MUX_ARBITER_ROTATE_EN
        m_ptr = (g + 1) % 8;
`endif
      end
    end
    check("valid", {7'b0, vout}, {7'b0, m_valid});
    check("data", {4'b0, dout}, {4'b0, m_data});
    check("way", wout, m_way);
    @(negedge clk);
  endtask
  initial begin
    logic [3:0] seq [9];
`ifdef ROUND_ROBIN_MUX_ARBITER_ROTATE_EN
    seq = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hd, 4'hc, 4'hb, 4'ha, 4'h4};
`else
    seq = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};
`endif
    @(negedge clk);
    step(8'hff, 1'b1, 1'b1);
    step(8'hff, 1'b1, 1'b1);
    check("rst_valid", {7'b0, vout}, 8'h00);
    check("rst_way", wout, 8'h00);
    step(8'h20, 1'b1, 1'b0);
    check("single_ack", last_ack, 8'h20);
    check("single_data", {4'b0, dout}, 8'h0c);
    step(8'hff, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(8'hff, 1'b1, 1'b0);
      check("all_seq", {4'b0, dout}, {4'b0, seq[i]});
    end
    step(8'hff, 1'b1, 1'b1);
    step(8'h20, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(8'hff, 1'b0, 1'b0);
      check("stall_ack", last_ack, 8'h00);
      check("stall_data", {4'b0, dout}, 8'h0c);
      check("stall_way", wout, 8'h20);
    end
    step(8'hff, 1'b1, 1'b0);
`ifdef ROUND_ROBIN_MUX_ARBITER_ROTATE_EN
    check("resume_ack", last_ack, 8'h40);
    check("resume_data", {4'b0, dout}, 8'h0b);
    step(8'hff, 1'b1, 1'b1);
    step(8'h04, 1'b1, 1'b0);
    step(8'h0a, 1'b1, 1'b0);
    check("fair_first", last_ack, 8'h08);
    step(8'h02, 1'b1, 1'b0);
    check("fair_second", last_ack, 8'h02);
`endif
    step(8'hff, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(8'hff, 1'b1, 1'b0);
    step(8'hff, 1'b1, 1'b1);
    check("midrst_valid", {7'b0, vout}, 8'h00);
    step(8'hff, 1'b1, 1'b0);
    check("midrst_ack", last_ack, 8'h01);
    for (int i = 0; i < 60; i++)
      step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
